// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: shared atomic-operation encodings and FSM state type for data_mem_responder
// Contents: atop field widths, ATOP_VALID bit index, amo_op_e funct5 codes,
// AMO_LR/AMO_SC constants, amo_legal() helper and the responder state enum.
package data_mem_resp_pkg;
    localparam int ATOP_W      = 6;
    localparam int AMO_FUNCT_W = 5;
    localparam int ATOP_VALID  = 5;

    typedef enum logic [AMO_FUNCT_W-1:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_op_e;

    // Reservation-based atomics are not supported by this memory.
    localparam logic [AMO_FUNCT_W-1:0] AMO_LR = 5'b00010;
    localparam logic [AMO_FUNCT_W-1:0] AMO_SC = 5'b00011;

    typedef enum logic {IDLE, AMO_WR} state_e;

    function automatic logic amo_legal(input logic [AMO_FUNCT_W-1:0] f);
        return f inside {AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
                         AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU};
    endfunction
endpackage

// File: rtl/data_mem_amo_alu.sv
// data_mem_amo_alu: combinational read-modify-write ALU for the atomic path
// Ports: op (funct5 operation), old (word read from memory), operand (store data),
// result (word written back).
module data_mem_amo_alu
    import data_mem_resp_pkg::*;
(
    input  amo_op_e     op,
    input  logic [31:0] old,
    input  logic [31:0] operand,
    output logic [31:0] result
);
    always_comb begin
        case (op)
            AMO_SWAP: result = operand;
            AMO_XOR:  result = old ^ operand;
            AMO_OR:   result = old | operand;
            AMO_AND:  result = old & operand;
            AMO_MIN:  result = $signed(old) < $signed(operand) ? old : operand;
            AMO_MAX:  result = $signed(old) > $signed(operand) ? old : operand;
            AMO_MINU: result = old < operand ? old : operand;
            AMO_MAXU: result = old > operand ? old : operand;
            default:  result = old + operand;
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: flop-based word memory acting as responder on the core data interface
// Ports: clk_i, rst_ni (async active-low); req_i/gnt_o/err_o request handshake;
// addr_i, we_i, be_i, wdata_i, atop_i, buffer_i request fields; rvalid_o/rdata_o response.
// Define DATA_MEM_RESPONDER_ATOMICS_EN to compile in the atomic read-modify-write path;
// without it every atomic request is answered as an error.
module data_mem_responder
    import data_mem_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          NUM_WORDS    = 1024,
    parameter int          RESP_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    input  logic [ATOP_W-1:0] atop_i,
    input  logic              buffer_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o
);
    localparam int IW = $clog2(NUM_WORDS);

    logic [31:0]             mem [NUM_WORDS];
    logic [31:0]             off;
    logic [IW-1:0]           idx;
    logic                    in_range, is_amo, amo_ok, err, amo_wr, do_store;
    logic [IW-1:0]           amo_idx;
    logic [31:0]             amo_new, resp_data;
    state_e                  state;
    logic [RESP_LATENCY-1:0] pipe_v;
    logic [31:0]             pipe_d [RESP_LATENCY];
    logic                    unused;

    // Subtraction wraps for addresses below BASE_ADDR, so that case is caught explicitly.
    assign off       = addr_i - BASE_ADDR;
    assign idx       = off[IW+1:2];
    assign in_range  = addr_i >= BASE_ADDR && {2'b00, off[31:2]} < 32'(NUM_WORDS);
    assign is_amo    = atop_i[ATOP_VALID];
    assign err       = !in_range || (is_amo && !amo_ok);
    assign gnt_o     = rst_ni && req_i && state == IDLE;
    assign err_o     = gnt_o && err;
    assign do_store  = gnt_o && !err && we_i && !is_amo;
    // Loads and atomics answer with the word as it stands in the grant cycle.
    assign resp_data = (gnt_o && !err && (is_amo || !we_i)) ? mem[idx] : 32'h0;
    assign unused    = ^{buffer_i, off[1:0], atop_i};

`ifdef DATA_MEM_RESPONDER_ATOMICS_EN
    logic [31:0] amo_old, amo_operand;
    amo_op_e     amo_op;

    assign amo_ok = amo_legal(atop_i[AMO_FUNCT_W-1:0]) && be_i == 4'hF;
    assign amo_wr = state == AMO_WR;

    data_mem_amo_alu u_alu (
        .op      (amo_op),
        .old     (amo_old),
        .operand (amo_operand),
        .result  (amo_new)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            amo_old     <= '0;
            amo_operand <= '0;
            amo_op      <= AMO_ADD;
            amo_idx     <= '0;
        end else if (state == IDLE && gnt_o && is_amo && !err) begin
            state       <= AMO_WR;
            amo_old     <= mem[idx];
            amo_operand <= wdata_i;
            amo_op      <= amo_op_e'(atop_i[AMO_FUNCT_W-1:0]);
            amo_idx     <= idx;
        end else begin
            state       <= IDLE;
        end
    end
`else
    assign amo_ok  = 1'b0;
    assign amo_wr  = 1'b0;
    assign amo_idx = '0;
    assign amo_new = '0;
    assign state   = IDLE;
`endif

    // Array contents survive reset; a reset during AMO_WR returns the FSM to IDLE
    // before the next edge, so the pending atomic write is never performed.
    always_ff @(posedge clk_i) begin
        if (amo_wr) begin
            mem[amo_idx] <= amo_new;
        end else if (do_store) begin
            for (int b = 0; b < 4; b++)
                if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_v <= '0;
            for (int i = 0; i < RESP_LATENCY; i++) pipe_d[i] <= '0;
        end else begin
            pipe_v[0] <= gnt_o;
            pipe_d[0] <= resp_data;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign rvalid_o = pipe_v[RESP_LATENCY-1];
    assign rdata_o  = pipe_d[RESP_LATENCY-1];
endmodule
